uart_tx: RTL and testbench

UART transmitter, the transmit-side counterpart to the design's UART receiver. It serializes 8-bit bytes onto a single line using 8N1 framing: one start bit (0), 8 data bits LSB first, one stop bit (1), no parity. A small FIFO sits in front of the serializer so the host controller can queue several bytes without waiting for each frame to finish. The block lives in the UART controller alongside the receiver and drives the board's TX pin.

---
 rtl/uart_tx_if.sv | 30 +++
 rtl/uart_tx.sv | 187 ++++++++++++++++++
 tb/tb_uart_tx.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_if.sv
// Host-side bundle for the UART transmitter: byte write strobe, FIFO status and line outputs.
interface uart_tx_if;
  logic       i_Tx_DV;
  logic [7:0] i_Tx_Byte;
  logic       o_Tx_Serial;
  logic       o_Tx_Active;
  logic       o_Tx_Done;
  logic       o_Tx_Full;
  logic       o_Tx_Empty;

  modport master (
    output i_Tx_DV,
    output i_Tx_Byte,
    input  o_Tx_Serial,
    input  o_Tx_Active,
    input  o_Tx_Done,
    input  o_Tx_Full,
    input  o_Tx_Empty
  );

  modport slave (
    input  i_Tx_DV,
    input  i_Tx_Byte,
    output o_Tx_Serial,
    output o_Tx_Active,
    output o_Tx_Done,
    output o_Tx_Full,
    output o_Tx_Empty
  );
endinterface

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a small byte FIFO ahead of the serializer.
// All outputs are registered; the frame is shifted from a private shift register.
module uart_tx #(
  parameter int CLKS_PER_BIT = 217,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic     i_CLK,
  input  logic     i_RST,
  uart_tx_if.slave bus
);

  localparam int                 PTR_W      = $clog2(FIFO_DEPTH);
  localparam int                 CNT_W      = PTR_W + 1;
  localparam logic [15:0]        LAST_COUNT = 16'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]   DEPTH_C    = CNT_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_START   = 3'd1,
    S_DATA    = 3'd2,
    S_STOP    = 3'd3,
    S_CLEANUP = 3'd4
  } state_t;

  // FIFO storage and bookkeeping
  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_d;
  logic             full_q;
  logic             empty_q;
  logic             push;
  logic             pop;

  // Serializer state
  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shift_q, shift_d;
  logic        serial_q, serial_d;
  logic        active_q, active_d;
  logic        done_q, done_d;

  // A pop frees a slot only after this edge, so a full FIFO still refuses the write.
  assign push = bus.i_Tx_DV && !full_q;

  always_comb begin
    count_d = count;
    case ({push, pop})
      2'b10:   count_d = count + CNT_W'(1);
      2'b01:   count_d = count - CNT_W'(1);
      default: count_d = count;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count   <= count_d;
      full_q  <= (count_d == DEPTH_C);
      empty_q <= (count_d == '0);
    end
  end

  // NOTE: the byte array has no reset; its contents are only read after a
  // write, and resetting it would force flops where RAM/LUTRAM suffices.
  always_ff @(posedge i_CLK) begin
    if (push) mem[wr_ptr] <= bus.i_Tx_Byte;
  end

  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      serial_q  <= 1'b1;
      active_q  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      serial_q  <= serial_d;
      active_q  <= active_d;
      done_q    <= done_d;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    serial_d  = serial_q;
    active_d  = active_q;
    done_d    = 1'b0;
    pop       = 1'b0;

    case (state_q)
      S_IDLE: begin
        serial_d  = 1'b1;
        active_d  = 1'b0;
        cnt_d     = '0;
        bit_idx_d = '0;
        if (!empty_q) begin
          pop      = 1'b1;
          shift_d  = mem[rd_ptr];
          serial_d = 1'b0;
          active_d = 1'b1;
          state_d  = S_START;
        end
      end

      S_START: begin
        if (cnt_q == LAST_COUNT) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          serial_d  = shift_q[0];
          state_d   = S_DATA;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      S_DATA: begin
        if (cnt_q == LAST_COUNT) begin
          cnt_d = '0;
          if (bit_idx_q == 3'd7) begin
            serial_d = 1'b1;
            state_d  = S_STOP;
          end else begin
            // LSB first: shift down and present the next bit.
            bit_idx_d = bit_idx_q + 3'd1;
            shift_d   = {1'b0, shift_q[7:1]};
            serial_d  = shift_q[1];
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      S_STOP: begin
        if (cnt_q == LAST_COUNT) begin
          cnt_d    = '0;
          active_d = 1'b0;
          done_d   = 1'b1;
          state_d  = S_CLEANUP;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      S_CLEANUP: begin
        serial_d = 1'b1;
        state_d  = S_IDLE;
      end

      default: begin
        serial_d = 1'b1;
        active_d = 1'b0;
        cnt_d    = '0;
        state_d  = S_IDLE;
      end
    endcase
  end

  assign bus.o_Tx_Serial = serial_q;
  assign bus.o_Tx_Active = active_q;
  assign bus.o_Tx_Done   = done_q;
  assign bus.o_Tx_Full   = full_q;
  assign bus.o_Tx_Empty  = empty_q;

endmodule

// File: tb/tb_uart_tx.sv
// Randomized bench for uart_tx: a frame-level timeline model predicts the line and
// status every cycle; a second instance at the default bit rate checks slot widths.
module tb_uart_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * CPB;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_tx_if bus4 ();
  uart_tx_if bus217 ();

  uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut4 (
    .i_CLK(clk),
    .i_RST(rst),
    .bus  (bus4.slave)
  );

  uart_tx dut217 (
    .i_CLK(clk),
    .i_RST(rst),
    .bus  (bus217.slave)
  );

  int n_vec = 0;
  int n_err = 0;

  // Timeline model: bytes waiting, the edge the current frame was popped on,
  // and the first edge at which the transmitter may pop again.
  logic [7:0] q[$];
  logic [7:0] cur;
  int         t         = 0;
  int         pop_edge  = -1;
  int         ready_at  = 0;
  int         done_exp  = 0;
  int         done_seen = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // {serial, active, done, full, empty} expected in the cycle after edge k.
  function automatic logic [4:0] model_out(input int k);
    logic s = 1'b1;
    logic a = 1'b0;
    logic d;
    int   slot;
    if (pop_edge >= 0 && k >= pop_edge && k - pop_edge < FRAME) begin
      slot = (k - pop_edge) / CPB;
      a    = 1'b1;
      if (slot == 0)      s = 1'b0;
      else if (slot == 9) s = 1'b1;
      else                s = cur[slot-1];
    end
    d = (pop_edge >= 0) && (k == pop_edge + FRAME);
    return {s, a, d, q.size() == DEPTH, q.size() == 0};
  endfunction

  task automatic cycle(input logic dv, input logic [7:0] b);
    logic       acc;
    logic [4:0] exp;
    bus4.i_Tx_DV   = dv;
    bus4.i_Tx_Byte = b;
    @(posedge clk);
    acc = dv && (q.size() < DEPTH);
    if (t >= ready_at && q.size() != 0) begin
      cur      = q.pop_front();
      pop_edge = t;
      ready_at = t + FRAME + 2;
    end
    if (acc) q.push_back(b);
    #1;
    exp = model_out(t);
    check("line", {bus4.o_Tx_Serial, bus4.o_Tx_Active, bus4.o_Tx_Done,
                   bus4.o_Tx_Full, bus4.o_Tx_Empty}, {27'd0, exp});
    if (exp[2]) done_exp++;
    if (bus4.o_Tx_Done) done_seen++;
    t++;
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(1'b0, 8'h00);
  endtask

  task automatic mid_cycle_reset();
    bus4.i_Tx_DV = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("rst_serial", bus4.o_Tx_Serial, 1);
    check("rst_active", bus4.o_Tx_Active, 0);
    check("rst_empty",  bus4.o_Tx_Empty,  1);
    check("rst_full",   bus4.o_Tx_Full,   0);
    q.delete();
    pop_edge = -1;
    ready_at = 0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [7:0] rx;
    logic       level;
    int         lat;
    int         cnt;
    int         guard;

    rst = 1'b1;
    bus4.i_Tx_DV     = 1'b0;
    bus4.i_Tx_Byte   = 8'h00;
    bus217.i_Tx_DV   = 1'b0;
    bus217.i_Tx_Byte = 8'h00;
    #12;
    check("reset_state", {bus4.o_Tx_Serial, bus4.o_Tx_Active, bus4.o_Tx_Done,
                          bus4.o_Tx_Full, bus4.o_Tx_Empty}, 5'b10001);
    check("reset_state217", {bus217.o_Tx_Serial, bus217.o_Tx_Active, bus217.o_Tx_Done,
                             bus217.o_Tx_Full, bus217.o_Tx_Empty}, 5'b10001);
    @(negedge clk);
    rst = 1'b0;
    idle(3);

    // Single byte, then back-to-back extremes.
    cycle(1'b1, 8'hA5);
    idle(FRAME + 6);
    check("done_single", done_seen, done_exp);
    cycle(1'b1, 8'h00);
    cycle(1'b1, 8'hFF);
    idle(2 * (FRAME + 2) + 6);
    check("done_b2b", done_seen, done_exp);

    // Overflow: six writes into a four-deep FIFO while the first frame runs.
    for (int i = 0; i < 6; i++) cycle(1'b1, 8'(8'h11 + i));
    idle(5 * (FRAME + 2) + 6);
    check("done_overflow", done_seen, done_exp);

    // Write landing exactly on the edge that pops the next queued byte.
    for (int i = 0; i < 4; i++) cycle(1'b1, 8'(8'hC0 + i));
    guard = 0;
    while (t != ready_at && guard < 200) begin
      idle(1);
      guard++;
    end
    check("pop_edge_reached", guard < 200, 1);
    cycle(1'b1, 8'h5E);
    idle(5 * (FRAME + 2) + 6);

    // Random traffic, FIFO frequently full.
    repeat (900) cycle($urandom_range(0, 3) == 0, 8'($urandom));
    idle((DEPTH + 1) * (FRAME + 2) + 6);
    check("done_random", done_seen, done_exp);

    // Reset mid-frame with bytes still queued: nothing may follow release.
    for (int i = 0; i < 3; i++) cycle(1'b1, 8'($urandom));
    idle(10 + $urandom_range(0, 20));
    mid_cycle_reset();
    idle(2 * FRAME);

    // Default bit rate: slot widths and decoded byte.
    @(posedge clk);
    #1;
    bus217.i_Tx_DV   = 1'b1;
    bus217.i_Tx_Byte = 8'h55;
    @(posedge clk);
    #1;
    bus217.i_Tx_DV = 1'b0;
    lat = 0;
    while (bus217.o_Tx_Serial && lat < 10) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("latency217", lat, 1);
    rx = 8'h00;
    for (int slot = 0; slot < 9; slot++) begin
      level = bus217.o_Tx_Serial;
      if (slot > 0) rx[slot-1] = level;
      cnt = 0;
      while (bus217.o_Tx_Serial == level && cnt < 1000) begin
        cnt++;
        @(posedge clk);
        #1;
      end
      check($sformatf("slot217_%0d", slot), cnt, 217);
    end
    cnt = 0;
    while (bus217.o_Tx_Active && bus217.o_Tx_Serial && cnt < 1000) begin
      cnt++;
      @(posedge clk);
      #1;
    end
    check("stop217", cnt, 217);
    check("byte217", rx, 8'h55);
    check("done217_hi", bus217.o_Tx_Done, 1);
    @(posedge clk);
    #1;
    check("done217_lo", {bus217.o_Tx_Done, bus217.o_Tx_Active, bus217.o_Tx_Serial,
                         bus217.o_Tx_Empty}, 4'b0011);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
